// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_pkg
// Purpose  : Shared widths, entry record and sizing helper for the
//            reservation station.
// Revision : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int OPC_W = 5;
    localparam int PRF_W = 6;

    typedef struct packed {
        logic             valid;
        logic [OPC_W-1:0] opcode;
        logic [PRF_W-1:0] src1_prf;
        logic             src1_rdy;
        logic [PRF_W-1:0] src2_prf;
        logic             src2_rdy;
        logic [PRF_W-1:0] dest_prf;
    } rs_entry_t;

    // Width of a counter able to hold 0..n inclusive
    function automatic int occ_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_select
// Purpose  : One-hot grant over ready entries. Oldest-first when
//            RS_AGE_SELECT_EN is defined, lowest index otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module rs_select
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic [NUM_ENTRIES-1:0]             i_req,
`ifdef RS_AGE_SELECT_EN
    input  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] i_age,
`endif
    output logic [NUM_ENTRIES-1:0]             o_grant,
    output logic                               o_grant_valid
);

`ifdef RS_AGE_SELECT_EN
    // i_age[j*N+i] set means entry j is older than entry i
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_grant
            logic [NUM_ENTRIES-1:0] w_older;
            for (genvar gj = 0; gj < NUM_ENTRIES; gj++) begin : g_col
                assign w_older[gj] = i_age[gj*NUM_ENTRIES + gi];
            end
            assign o_grant[gi] = i_req[gi] && ((i_req & w_older) == '0);
        end
    endgenerate
`else
    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i_req[i] && !w_found) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
`endif

    assign o_grant_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Purpose  : N-entry unified reservation station with CDB wakeup and a
//            valid/ready issue port. Define RS_AGE_SELECT_EN for
//            oldest-ready-first select.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            disp_valid,
    output logic                            disp_ready,
    input  logic [OPC_W-1:0]                disp_opcode,
    input  logic [PRF_W-1:0]                disp_src1_prf,
    input  logic                            disp_src1_ready,
    input  logic [PRF_W-1:0]                disp_src2_prf,
    input  logic                            disp_src2_ready,
    input  logic [PRF_W-1:0]                disp_dest_prf,
    input  logic                            cdb_valid,
    input  logic [PRF_W-1:0]                cdb_tag,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [OPC_W-1:0]                issue_opcode,
    output logic [PRF_W-1:0]                issue_src1_prf,
    output logic [PRF_W-1:0]                issue_src2_prf,
    output logic [PRF_W-1:0]                issue_dest_prf,
    output logic [occ_w(NUM_ENTRIES)-1:0]   occupancy
);

    localparam int                 c_occ_w = occ_w(NUM_ENTRIES);
    localparam logic [c_occ_w-1:0] c_full  = c_occ_w'(NUM_ENTRIES);

    rs_entry_t                r_entry [NUM_ENTRIES];
    logic [c_occ_w-1:0]       r_occ;

    logic [NUM_ENTRIES-1:0]   w_req;
    logic [NUM_ENTRIES-1:0]   w_grant;
    logic                     w_grant_valid;
    logic [NUM_ENTRIES-1:0]   w_free_oh;
    logic                     w_free_found;
    logic [NUM_ENTRIES-1:0]   w_issue_oh;
    logic                     w_disp_fire;
    logic                     w_issue_fire;
    rs_entry_t                w_new;

    assign occupancy    = r_occ;
    assign disp_ready   = (r_occ != c_full);
    assign w_disp_fire  = disp_valid && disp_ready;
    assign issue_valid  = w_grant_valid;
    assign w_issue_fire = w_grant_valid && issue_ready;
    assign w_issue_oh   = w_grant & {NUM_ENTRIES{w_issue_fire}};

    // Request only from registered ready bits: no CDB-to-issue bypass
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_req[i] = r_entry[i].valid && r_entry[i].src1_rdy && r_entry[i].src2_rdy;
        end
    end

    always_comb begin
        w_free_oh    = '0;
        w_free_found = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!r_entry[i].valid && !w_free_found) begin
                w_free_oh[i] = 1'b1;
                w_free_found = 1'b1;
            end
        end
    end

    // A same-cycle broadcast on a dispatching source marks it ready on write
    always_comb begin
        w_new.valid    = 1'b1;
        w_new.opcode   = disp_opcode;
        w_new.src1_prf = disp_src1_prf;
        w_new.src1_rdy = disp_src1_ready || (cdb_valid && (cdb_tag == disp_src1_prf));
        w_new.src2_prf = disp_src2_prf;
        w_new.src2_rdy = disp_src2_ready || (cdb_valid && (cdb_tag == disp_src2_prf));
        w_new.dest_prf = disp_dest_prf;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
            r_occ <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_entry[i].valid && cdb_valid) begin
                    if (cdb_tag == r_entry[i].src1_prf) r_entry[i].src1_rdy <= 1'b1;
                    if (cdb_tag == r_entry[i].src2_prf) r_entry[i].src2_rdy <= 1'b1;
                end
                if (w_issue_oh[i]) begin
                    r_entry[i].valid <= 1'b0;
                end
                if (w_disp_fire && w_free_oh[i]) begin
                    r_entry[i] <= w_new;
                end
            end
            case ({w_disp_fire, w_issue_fire})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef RS_AGE_SELECT_EN
    logic [NUM_ENTRIES*NUM_ENTRIES-1:0] r_age;
    logic [NUM_ENTRIES-1:0]             w_keep;

    always_comb begin
        for (int j = 0; j < NUM_ENTRIES; j++) begin
            w_keep[j] = r_entry[j].valid && !w_issue_oh[j];
        end
    end

    // New entry: every surviving entry is older (column set), it is older
    // than nobody (row cleared). A freed entry drops its row and column.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_age <= '0;
        end else begin
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (w_disp_fire && w_free_oh[i]) begin
                        r_age[j*NUM_ENTRIES + i] <= w_keep[j];
                    end
                    if ((w_disp_fire && w_free_oh[j]) || w_issue_oh[j] || w_issue_oh[i]) begin
                        r_age[j*NUM_ENTRIES + i] <= 1'b0;
                    end
                end
            end
        end
    end

    rs_select #(
        .NUM_ENTRIES   (NUM_ENTRIES)
    ) u_select (
        .i_req         (w_req),
        .i_age         (r_age),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );
`else
    rs_select #(
        .NUM_ENTRIES   (NUM_ENTRIES)
    ) u_select (
        .i_req         (w_req),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );
`endif

    always_comb begin
        issue_opcode   = '0;
        issue_src1_prf = '0;
        issue_src2_prf = '0;
        issue_dest_prf = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            issue_opcode   = issue_opcode   | (r_entry[i].opcode   & {OPC_W{w_grant[i]}});
            issue_src1_prf = issue_src1_prf | (r_entry[i].src1_prf & {PRF_W{w_grant[i]}});
            issue_src2_prf = issue_src2_prf | (r_entry[i].src2_prf & {PRF_W{w_grant[i]}});
            issue_dest_prf = issue_dest_prf | (r_entry[i].dest_prf & {PRF_W{w_grant[i]}});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Directed self-checking bench with an issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    typedef struct packed {
        logic [4:0] op;
        logic [5:0] s1;
        logic [5:0] s2;
        logic [5:0] d;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       disp_valid;
    logic       disp_ready;
    logic [4:0] disp_opcode;
    logic [5:0] disp_src1_prf;
    logic       disp_src1_ready;
    logic [5:0] disp_src2_prf;
    logic       disp_src2_ready;
    logic [5:0] disp_dest_prf;
    logic       cdb_valid;
    logic [5:0] cdb_tag;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_opcode;
    logic [5:0] issue_src1_prf;
    logic [5:0] issue_src2_prf;
    logic [5:0] issue_dest_prf;
    logic [3:0] occupancy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    reservation_station #(.NUM_ENTRIES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_opcode     (disp_opcode),
        .disp_src1_prf   (disp_src1_prf),
        .disp_src1_ready (disp_src1_ready),
        .disp_src2_prf   (disp_src2_prf),
        .disp_src2_ready (disp_src2_ready),
        .disp_dest_prf   (disp_dest_prf),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .issue_opcode    (issue_opcode),
        .issue_src1_prf  (issue_src1_prf),
        .issue_src2_prf  (issue_src2_prf),
        .issue_dest_prf  (issue_dest_prf),
        .occupancy       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake is sampled at the falling edge, then the rising edge commits
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (issue_valid && issue_ready) begin
            n_tests++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_issue: observed op %0h, expected no issue", issue_opcode);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_issue_fields", {9'd0, issue_opcode, issue_src1_prf, issue_src2_prf, issue_dest_prf}, {9'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_disp(input logic [4:0] op, input logic [5:0] s1, input logic r1,
                              input logic [5:0] s2, input logic r2, input logic [5:0] d);
        disp_valid      = 1'b1;
        disp_opcode     = op;
        disp_src1_prf   = s1;
        disp_src1_ready = r1;
        disp_src2_prf   = s2;
        disp_src2_ready = r2;
        disp_dest_prf   = d;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0;
        disp_src1_prf = '0; disp_src1_ready = 1'b0; disp_src2_prf = '0;
        disp_src2_ready = 1'b0; disp_dest_prf = '0; cdb_valid = 1'b0;
        cdb_tag = '0; issue_ready = 1'b0;
        @(posedge clk); #1;
        tick();
        reset = 1'b0;
        chk("reset_occupancy", occupancy, 0);
        chk("reset_disp_ready", disp_ready, 1);
        chk("reset_issue_valid", issue_valid, 0);
        chk("reset_issue_opcode", issue_opcode, 0);

        // Fully ready op issues the cycle after dispatch
        drive_disp(5'h03, 6'd10, 1'b1, 6'd11, 1'b1, 6'd20);
        sb_q.push_back('{5'h03, 6'd10, 6'd11, 6'd20});
        tick();
        disp_valid = 1'b0;
        chk("t1_issue_valid", issue_valid, 1);
        chk("t1_occupancy", occupancy, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t1_occ_after", occupancy, 0);
        chk("t1_issue_valid_after", issue_valid, 0);

        // CDB wakeup visible only one cycle after the broadcast
        drive_disp(5'h04, 6'd12, 1'b0, 6'd13, 1'b1, 6'd21);
        sb_q.push_back('{5'h04, 6'd12, 6'd13, 6'd21});
        tick();
        disp_valid = 1'b0;
        chk("t2_not_ready_c1", issue_valid, 0);
        tick();
        cdb_valid = 1'b1; cdb_tag = 6'd12;
        chk("t2_no_bypass", issue_valid, 0);
        tick();
        cdb_valid = 1'b0;
        chk("t2_woken", issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t2_occ_after", occupancy, 0);

        // Both sources share tag 0; one broadcast wakes both
        drive_disp(5'h06, 6'd0, 1'b0, 6'd0, 1'b0, 6'd23);
        sb_q.push_back('{5'h06, 6'd0, 6'd0, 6'd23});
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd0;
        chk("t2b_not_ready", issue_valid, 0);
        tick();
        cdb_valid = 1'b0;
        chk("t2b_both_woken", issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Broadcast coinciding with dispatch is captured on write
        drive_disp(5'h05, 6'd1, 1'b1, 6'd7, 1'b0, 6'd22);
        cdb_valid = 1'b1; cdb_tag = 6'd7;
        sb_q.push_back('{5'h05, 6'd1, 6'd7, 6'd22});
        tick();
        disp_valid = 1'b0; cdb_valid = 1'b0;
        chk("t3_issuable", issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t3_occ_after", occupancy, 0);

        // Fill, full back-pressure, then dispatch+issue together at 7
        for (int k = 0; k < 8; k++) begin
            chk("t4_disp_ready_fill", disp_ready, 1);
            drive_disp(5'(k + 8), 6'(k), 1'b1, 6'(k + 1), 1'b1, 6'(k + 30));
            sb_q.push_back('{5'(k + 8), 6'(k), 6'(k + 1), 6'(k + 30)});
            tick();
        end
        disp_valid = 1'b0;
        chk("t4_occ_full", occupancy, 8);
        chk("t4_disp_ready_full", disp_ready, 0);
        issue_ready = 1'b1;
        tick();
        chk("t4_occ_7", occupancy, 7);
        drive_disp(5'h1f, 6'd60, 1'b0, 6'd2, 1'b1, 6'd61);
        sb_q.push_back('{5'h1f, 6'd60, 6'd2, 6'd61});
        tick();
        disp_valid = 1'b0;
        chk("t4_occ_disp_issue", occupancy, 7);
        repeat (6) tick();
        chk("t4_occ_drained", occupancy, 1);
        chk("t4_unready_held", issue_valid, 0);
        issue_ready = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd60;
        tick();
        cdb_valid = 1'b0;
        chk("t4_last_woken", issue_valid, 1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t4_occ_empty", occupancy, 0);

        // Age versus index select: B (entry 1) older than C (entry 0)
        drive_disp(5'h0a, 6'd40, 1'b0, 6'd1, 1'b1, 6'd50);
        tick();
        drive_disp(5'h0b, 6'd41, 1'b0, 6'd1, 1'b1, 6'd51);
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd40;
        tick();
        cdb_valid = 1'b0;
        sb_q.push_back('{5'h0a, 6'd40, 6'd1, 6'd50});
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        drive_disp(5'h0c, 6'd41, 1'b0, 6'd1, 1'b1, 6'd52);
        tick();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 6'd41;
        tick();
        cdb_valid = 1'b0;
`ifdef RS_AGE_SELECT_EN
        chk("t5_oldest_first", issue_opcode, 5'h0b);
        sb_q.push_back('{5'h0b, 6'd41, 6'd1, 6'd51});
        sb_q.push_back('{5'h0c, 6'd41, 6'd1, 6'd52});
`else
        chk("t5_lowest_index", issue_opcode, 5'h0c);
        sb_q.push_back('{5'h0c, 6'd41, 6'd1, 6'd52});
        sb_q.push_back('{5'h0b, 6'd41, 6'd1, 6'd51});
`endif
        issue_ready = 1'b1;
        tick();
        tick();
        issue_ready = 1'b0;
        chk("t5_occ_after", occupancy, 0);

        // Flush beats a concurrent dispatch
        for (int k = 0; k < 5; k++) begin
            drive_disp(5'(k + 1), 6'(k + 2), 1'b1, 6'(k + 3), 1'b1, 6'(k + 4));
            tick();
        end
        chk("t6_occ_5", occupancy, 5);
        drive_disp(5'h11, 6'd5, 1'b1, 6'd6, 1'b1, 6'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0; disp_valid = 1'b0;
        chk("t6_occ_flushed", occupancy, 0);
        chk("t6_issue_valid", issue_valid, 0);
        chk("t6_issue_opcode", issue_opcode, 0);
        chk("t6_disp_ready", disp_ready, 1);

        chk("sb_leftover", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
